// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback
// stepping, memory req/ack handshakes with stall timeout, and retire counting.
module multi_cycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNTER_WIDTH  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_write_enable,
  output logic        pc_write_enable,
  output logic        register_write_gate,
  output logic [2:0]  state,
  output logic        fault,
  output logic        retired,
  output logic [31:0] retire_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_UNUSED    = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [COUNTER_WIDTH-1:0] r_wait;
  logic [COUNTER_WIDTH-1:0] w_wait_next;
  logic                     r_fault;
  logic [31:0]              r_retire_count;
  logic                     w_timeout;
  logic                     w_is_store;
  logic                     w_is_load;

  assign w_timeout  = (r_wait == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_is_store = (opcode == OP_STORE);
  assign w_is_load  = (opcode == OP_LOAD);

  always_comb begin
    w_state_next        = r_state;
    w_wait_next         = '0;
    imem_req            = 1'b0;
    dmem_req            = 1'b0;
    dmem_we             = 1'b0;
    ir_write_enable     = 1'b0;
    pc_write_enable     = 1'b0;
    register_write_gate = 1'b0;
    retired             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_write_enable = 1'b1;
          w_state_next    = S_DECODE;
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_DECODE: begin
        w_state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_state_next = S_MEMORY;
          OP_OP, OP_OPIMM, OP_BRANCH, OP_JALR,
          OP_JAL, OP_LUI, OP_AUIPC: w_state_next = S_WRITEBACK;
          default: w_state_next = S_FAULT;
        endcase
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_store;
        if (dmem_ack) begin
          // Stores retire straight out of MEMORY; nothing to write back.
          if (w_is_store) begin
            pc_write_enable = 1'b1;
            retired         = 1'b1;
            w_state_next    = run ? S_FETCH : S_IDLE;
          end else if (w_is_load) begin
            w_state_next = S_WRITEBACK;
          end else begin
            w_state_next = S_FAULT;
          end
        end else if (w_timeout) begin
          w_state_next = S_FAULT;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      S_WRITEBACK: begin
        pc_write_enable     = 1'b1;
        retired             = 1'b1;
        register_write_gate = (opcode != OP_BRANCH) && !w_is_store;
        w_state_next        = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wait         <= '0;
      r_fault        <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_fault <= (w_state_next == S_FAULT);
      if (retired) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign state        = r_state;
  assign fault        = r_fault;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer: ALU, load, store, timeout,
// illegal opcode, run drop and counter wrap scenarios.
module tb_multi_cycle_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [6:0]  opcode;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        ir_write_enable;
  logic        pc_write_enable;
  logic        register_write_gate;
  logic [2:0]  state;
  logic        fault;
  logic        retired;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  multi_cycle_sequencer #(.TIMEOUT_CYCLES(16), .COUNTER_WIDTH(5)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .run                 (run),
    .opcode              (opcode),
    .imem_req            (imem_req),
    .imem_ack            (imem_ack),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_ack            (dmem_ack),
    .ir_write_enable     (ir_write_enable),
    .pc_write_enable     (pc_write_enable),
    .register_write_gate (register_write_gate),
    .state               (state),
    .fault               (fault),
    .retired             (retired),
    .retire_count        (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int alu_seq[4]  = '{1, 2, 3, 5};
  int load_seq[8] = '{1, 2, 3, 4, 4, 4, 4, 5};
  int st_seq[4]   = '{1, 2, 3, 4};

  initial begin
    rst = 1'b1; run = 1'b0; opcode = 7'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    tick(); tick();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", retire_count, 32'd0);

    // ALU stream: OP-IMM, imem_ack tied high
    run = 1'b1; opcode = 7'b0010011; imem_ack = 1'b1;
    #1;
    chk("rst_held_imem_req", 32'(imem_req), 32'd0);
    chk("rst_held_ir_we", 32'(ir_write_enable), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rel_state", 32'(state), 32'd0);
    chk("post_rel_imem_req", 32'(imem_req), 32'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      #1;
      chk($sformatf("alu_state_%0d", i), 32'(state), 32'(alu_seq[i % 4]));
      chk($sformatf("alu_retired_%0d", i), 32'(retired), 32'(alu_seq[i % 4] == 5));
      chk($sformatf("alu_rwg_%0d", i), 32'(register_write_gate), 32'(alu_seq[i % 4] == 5));
      if (i % 4 == 0) chk($sformatf("alu_irwe_%0d", i), 32'(ir_write_enable), 32'd1);
      tick();
    end
    #1;
    chk("alu_count", retire_count, 32'd3);

    // LOAD with dmem_ack on the 4th MEMORY cycle
    opcode = 7'b0000011;
    for (int i = 0; i < 8; i++) begin
      dmem_ack = (i == 6);
      #1;
      chk($sformatf("ld_state_%0d", i), 32'(state), 32'(load_seq[i]));
      chk($sformatf("ld_dreq_%0d", i), 32'(dmem_req), 32'(load_seq[i] == 4));
      chk($sformatf("ld_dwe_%0d", i), 32'(dmem_we), 32'd0);
      chk($sformatf("ld_retired_%0d", i), 32'(retired), 32'(load_seq[i] == 5));
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    chk("ld_count", retire_count, 32'd4);

    // STORE with immediate acks; dmem_ack high in FETCH must be ignored
    opcode = 7'b0100011; dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("st_state_%0d", i), 32'(state), 32'(st_seq[i]));
      chk($sformatf("st_dwe_%0d", i), 32'(dmem_we), 32'(st_seq[i] == 4));
      chk($sformatf("st_pcwe_%0d", i), 32'(pc_write_enable), 32'(st_seq[i] == 4));
      chk($sformatf("st_retired_%0d", i), 32'(retired), 32'(st_seq[i] == 4));
      chk($sformatf("st_rwg_%0d", i), 32'(register_write_gate), 32'd0);
      tick();
    end
    dmem_ack = 1'b0;
    #1;
    chk("st_count", retire_count, 32'd5);
    chk("st_next_state", 32'(state), 32'd1);

    // Fetch timeout: 16 unacked request cycles then FAULT
    imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk($sformatf("to_state_%0d", i), 32'(state), 32'd1);
      chk($sformatf("to_ireq_%0d", i), 32'(imem_req), 32'd1);
      tick();
    end
    #1;
    chk("to_fault_state", 32'(state), 32'd7);
    chk("to_fault_flag", 32'(fault), 32'd1);
    chk("to_fault_ireq", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("to_rst_state", 32'(state), 32'd0);
    chk("to_rst_fault", 32'(fault), 32'd0);
    chk("to_rst_count", retire_count, 32'd0);
    rst = 1'b0;
    tick();

    // Second run: ack arrives in the 16th FETCH cycle
    for (int i = 0; i < 16; i++) begin
      imem_ack = (i == 15);
      #1;
      chk($sformatf("late_state_%0d", i), 32'(state), 32'd1);
      tick();
    end
    imem_ack = 1'b1;
    opcode = 7'b1111111;
    #1;
    chk("late_decode", 32'(state), 32'd2);
    chk("late_fault", 32'(fault), 32'd0);

    // Unsupported opcode faults out of EXECUTE and stays faulted
    tick();
    #1;
    chk("bad_exec", 32'(state), 32'd3);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bad_state_%0d", i), 32'(state), 32'd7);
      chk($sformatf("bad_fault_%0d", i), 32'(fault), 32'd1);
      chk($sformatf("bad_ireq_%0d", i), 32'(imem_req), 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("bad_rst_state", 32'(state), 32'd0);
    chk("bad_rst_fault", 32'(fault), 32'd0);
    chk("bad_rst_count", retire_count, 32'd0);

    // BRANCH with run dropped in DECODE, counter wraps on its retire
    opcode = 7'b1100011;
    rst = 1'b0;
    tick();
    #1;
    chk("br_fetch", 32'(state), 32'd1);
    tick();
    run = 1'b0;
    dut.r_retire_count = 32'hFFFF_FFFF;
    #1;
    chk("br_decode", 32'(state), 32'd2);
    tick();
    #1;
    chk("br_exec", 32'(state), 32'd3);
    tick();
    #1;
    chk("br_wb_state", 32'(state), 32'd5);
    chk("br_wb_retired", 32'(retired), 32'd1);
    chk("br_wb_pcwe", 32'(pc_write_enable), 32'd1);
    chk("br_wb_rwg", 32'(register_write_gate), 32'd0);
    chk("br_wb_count", retire_count, 32'hFFFF_FFFF);
    tick();
    #1;
    chk("br_idle", 32'(state), 32'd0);
    chk("br_wrap", retire_count, 32'd0);
    tick();
    #1;
    chk("br_idle_hold", 32'(state), 32'd0);
    chk("br_idle_ireq", 32'(imem_req), 32'd0);

    // Reset mid-FETCH drops the request without a clock edge
    run = 1'b1; imem_ack = 1'b0;
    tick();
    #1;
    chk("mid_fetch_ireq", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ireq", 32'(imem_req), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_sequencer.md
Name: multi_cycle_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and generates the enables that gate the combinational instruction decoder's outputs onto the shared datapath. It also runs the instruction-memory and data-memory req/ack handshakes, detects stalled memory and unsupported opcodes, and counts retired instructions.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive cycles a memory request may wait for ack before FAULT (legal range 2..31)
COUNTER_WIDTH, 5, width of the wait counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  in  1  core clock, all state changes on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  start/continue; low = halt in IDLE after the current instruction retires
opcode  in  7  instruction[6:0] from the instruction register; valid from DECODE onward
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid this cycle
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data access complete this cycle
ir_write_enable  out  1  latch fetched instruction into IR
pc_write_enable  out  1  commit next PC
register_write_gate  out  1  qualifies decoder register_write_enable
state  out  3  current state encoding
fault  out  1  sticky error flag
retired  out  1  one-cycle pulse per committed instruction
retire_count  out  32  retired-instruction counter

Behaviour:
- Reset (async, active-high): state=IDLE, wait counter=0, retire_count=0, fault=0; every output 0 while rst high and in the cycle after release.
- Encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=7; 6 unused, decodes to FAULT.
- All outputs are combinational from registered state plus inputs. No registered outputs except state, fault, retire_count.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1. imem_ack=1 -> ir_write_enable=1 same cycle, -> DECODE. Ack may arrive in the first FETCH cycle.
- DECODE: exactly 1 cycle -> EXECUTE.
- EXECUTE: exactly 1 cycle. Routing by opcode:
  - LOAD 0000011 or STORE 0100011 -> MEMORY.
  - OP 0110011, OP-IMM 0010011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111 -> WRITEBACK.
  - Any other opcode -> FAULT.
- MEMORY: dmem_req=1; dmem_we=1 iff STORE.
  - dmem_ack with LOAD -> WRITEBACK.
  - dmem_ack with STORE -> pc_write_enable=1 and retired=1 that cycle, then FETCH if run else IDLE.
- WRITEBACK: pc_write_enable=1, retired=1. register_write_gate=1 for every routed opcode except BRANCH and STORE. Next state FETCH if run else IDLE.
- Wait counter:
  - Cleared on entry to FETCH and MEMORY; increments each FETCH/MEMORY cycle without ack.
  - Counter==TIMEOUT_CYCLES-1 with no ack -> FAULT at next edge, i.e. TIMEOUT_CYCLES unacked request cycles.
  - Ack in that final cycle wins; no fault.
- FAULT: sticky until rst. fault=1; all req/enable/pulse outputs 0; run ignored.
- retire_count increments by 1 on every retired pulse and wraps 0xFFFFFFFF -> 0.
- Acks outside FETCH/MEMORY are ignored. An ack on the wrong port (dmem_ack in FETCH, imem_ack in MEMORY) has no effect.
- run deasserted mid-instruction: the instruction completes and retires, then the sequencer goes to IDLE. No partial commit.
- rst asserted mid-instruction: immediate IDLE, requests drop asynchronously, no retire.
- Latency with zero-wait memory: ALU/jump/branch 4 cycles; load 5; store 4; back-to-back retires every 4 cycles with run held high.

Test Plan:
- rst pulse, run=1, opcode=0010011, imem_ack tied 1 -> states 1,2,3,5 repeating; retired every 4th cycle; retire_count=3 after 12 cycles; register_write_gate=1 only in state 5.
- opcode=0000011, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; WRITEBACK follows; 8 cycles per instruction.
- opcode=0100011, immediate acks -> dmem_we=1 in MEMORY; pc_write_enable and retired in the MEMORY ack cycle; register_write_gate never 1.
- imem_ack held 0 in FETCH -> FAULT after exactly 16 request cycles. Second run with ack on cycle 16 -> DECODE, fault=0.
- opcode=1111111 -> FAULT from EXECUTE, fault=1 sticky, imem_req=0; asserting rst mid-FAULT -> IDLE, fault=0, retire_count=0.
- run dropped during DECODE of opcode 1100011 -> instruction retires with register_write_gate=0, then IDLE held; retire_count preset to 0xFFFFFFFF wraps to 0 on that retire.
